core_run_ctrl: RTL
==================

// Module: core_run_ctrl
// PURPOSE
//  Run-control sequencer for the CoreTop core: owns core reset, the core clock-gate enable and
//  the first_fetch_trigger pulse, and runs a kickable watchdog. On start it resets the core, launches
//  it, counts run cycles, and stops on halt, watchdog expiry or abort. Before gating the clock it
//  drains for a fixed number of cycles. Sits between platform/bench control and CoreTop + ClockGate.
// PARAMETERS
//  RST_CYCLES    10   cycles core_rstn_o held low in RESET (>=1)
//  WATCHDOG_TIM  200  consecutive un-kicked RUN cycles that expire the watchdog (>=2)
//  DRAIN_CYCLES  4    cycles clock stays enabled after a stop, before gating (>=1)
//  CNT_W         32   width of cycle_count_o
// PORTS
//  clk                    in   1      single clock
//  rst                    in   1      asynchronous reset, active-high
//  start_i                in   1      launch request (level sampled per cycle)
//  halt_i                 in   1      core reports end of program
//  kick_i                 in   1      watchdog clear
//  abort_i                in   1      external stop request
//  core_rstn_o            out  1      core reset, active-low
//  core_clk_en_o          out  1      ClockGate enable
//  first_fetch_trigger_o  out  1      one-cycle launch pulse to CoreTop
//  busy_o                 out  1      1 in RESET/LAUNCH/RUN/DRAIN
//  done_o                 out  1      1 in DONE
//  stop_cause_o           out  2      00 none, 01 halt, 10 watchdog, 11 abort
//  cycle_count_o          out  CNT_W  RUN cycles of last/current run
// BEHAVIOUR
//  - One clock clk; reset rst is asynchronous and active-high. All outputs are registered.
//  - rst asserted: state=IDLE; core_rstn_o=0, core_clk_en_o=0, trigger=0, busy=0, done=0, cause=00, count=0.
//  - States: IDLE, RESET, LAUNCH, RUN, DRAIN, DONE.
//    IDLE: core held in reset, clock gated. start_i -> RESET.
//    RESET: core_rstn_o=0, core_clk_en_o=1, for exactly RST_CYCLES cycles -> LAUNCH.
//    LAUNCH: core_rstn_o=1, clk_en=1, first_fetch_trigger_o=1 (this cycle only) -> RUN.
//    RUN: clk_en=1; cycle_count_o += 1 per cycle, saturating at all-ones; watchdog active.
//      Stops on abort_i, watchdog expiry or halt_i; sets cause and goes to DRAIN.
//    DRAIN: clk_en=1, core_rstn_o=1, for exactly DRAIN_CYCLES cycles -> DONE.
//    DONE: clk_en=0, core_rstn_o=1 (core state preserved for memory dump), done_o=1.
//      cause and count are held. start_i -> RESET.
//  - Timing: start_i high in IDLE at edge T -> RESET from T+1. core_rstn_o low T+1..T+RST_CYCLES.
//    Trigger high at T+RST_CYCLES+1, RUN from T+RST_CYCLES+2.
//  - Entering RESET from IDLE/DONE clears cycle_count_o=0, cause=00, done_o=0.
//  - Watchdog: counter cleared on entry to RUN and on any RUN cycle with kick_i=1.
//    Otherwise it increments. Expiry is the cycle the counter would reach WATCHDOG_TIM.
//    kick_i on that cycle wins, so there is no expiry.
//  - Simultaneous stop events in one RUN cycle: priority abort(11) > watchdog(10) > halt(01).
//  - abort_i in RESET or LAUNCH: go directly to DONE with cause=11. Clock gated next cycle; no trigger pulse.
//  - start_i ignored in RESET/LAUNCH/RUN/DRAIN. halt_i/kick_i ignored outside RUN.
//    abort_i ignored in IDLE/DRAIN/DONE.
//  - rst mid-run: immediate IDLE, clock gated, core in reset, status lost.
// TESTING
//  1. Default params, start pulse at T. Required: rstn low T+1..T+10, trigger only at T+11, RUN at T+12.
//     halt at T+61 -> cause=01, count=50, clk_en drops at T+66, done=1.
//  2. WATCHDOG_TIM=200, no kicks in RUN. Required: stop after 200 RUN cycles, cause=10, count=200.
//  3. Kick every 150 cycles for 1000 cycles, then halt. Required: no expiry; kick exactly on the
//     would-expire cycle also prevents expiry; cause=01.
//  4. halt, abort and expiry in the same cycle -> cause=11. halt+expiry in the same cycle -> cause=10.
//  5. abort during RESET (cycle 4) -> DONE next cycle, cause=11, trigger never pulses,
//     core_clk_en_o=0. Then start -> fresh run, count restarts from 0.
//  6. rst asserted mid-RUN -> outputs reach reset values asynchronously. CNT_W=4 -> count saturates at 15.

Source files
------------

// File: rtl/core_run_ctrl.sv
// Run-control sequencer for CoreTop: sequences core reset, launch trigger, watchdog-supervised run,
// drain, and final clock gating. All outputs are registered from the next-state decode.
module core_run_ctrl #(
  parameter int RST_CYCLES   = 10,
  parameter int WATCHDOG_TIM = 200,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             halt_i,
  input  logic             kick_i,
  input  logic             abort_i,
  output logic             core_rstn_o,
  output logic             core_clk_en_o,
  output logic             first_fetch_trigger_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       stop_cause_o,
  output logic [CNT_W-1:0] cycle_count_o
);

  localparam int SEQ_MAX = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam int WD_W    = $clog2(WATCHDOG_TIM + 1);

  localparam logic [SEQ_W-1:0] RST_LAST   = SEQ_W'(RST_CYCLES - 1);
  localparam logic [SEQ_W-1:0] DRAIN_LAST = SEQ_W'(DRAIN_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(WATCHDOG_TIM - 1);

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_HALT  = 2'b01;
  localparam logic [1:0] CAUSE_WDOG  = 2'b10;
  localparam logic [1:0] CAUSE_ABORT = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    LAUNCH,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [SEQ_W-1:0] seqCnt_q, seqCnt_d;
  logic [WD_W-1:0]  wdCnt_q, wdCnt_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rstn_q, rstn_d;
  logic             clkEn_q, clkEn_d;
  logic             trig_q, trig_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wdExpire;

  // Expiry is the cycle the counter would reach the limit; a kick in that same cycle wins.
  assign wdExpire = (wdCnt_q == WD_LAST) && !kick_i;

  always_comb begin
    state_d  = state_q;
    seqCnt_d = seqCnt_q;
    wdCnt_d  = wdCnt_q;
    cause_d  = cause_q;
    count_d  = count_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d  = RESET;
          seqCnt_d = '0;
          count_d  = '0;
          cause_d  = CAUSE_NONE;
        end
      end
      RESET: begin
        if (abort_i) begin
          state_d = DONE;
          cause_d = CAUSE_ABORT;
        end else if (seqCnt_q == RST_LAST) begin
          state_d = LAUNCH;
        end else begin
          seqCnt_d = seqCnt_q + SEQ_W'(1);
        end
      end
      LAUNCH: begin
        if (abort_i) begin
          state_d = DONE;
          cause_d = CAUSE_ABORT;
        end else begin
          state_d = RUN;
          wdCnt_d = '0;
        end
      end
      RUN: begin
        if (count_q != '1) begin
          count_d = count_q + CNT_W'(1);
        end
        wdCnt_d = kick_i ? '0 : wdCnt_q + WD_W'(1);
        if (abort_i || wdExpire || halt_i) begin
          state_d  = DRAIN;
          seqCnt_d = '0;
          if (abort_i) begin
            cause_d = CAUSE_ABORT;
          end else if (wdExpire) begin
            cause_d = CAUSE_WDOG;
          end else begin
            cause_d = CAUSE_HALT;
          end
        end
      end
      DRAIN: begin
        if (seqCnt_q == DRAIN_LAST) begin
          state_d = DONE;
        end else begin
          seqCnt_d = seqCnt_q + SEQ_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    rstn_d  = state_d inside {LAUNCH, RUN, DRAIN, DONE};
    clkEn_d = state_d inside {RESET, LAUNCH, RUN, DRAIN};
    busy_d  = state_d inside {RESET, LAUNCH, RUN, DRAIN};
    trig_d  = (state_d == LAUNCH);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      seqCnt_q <= '0;
      wdCnt_q  <= '0;
      cause_q  <= CAUSE_NONE;
      count_q  <= '0;
      rstn_q   <= 1'b0;
      clkEn_q  <= 1'b0;
      trig_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      seqCnt_q <= seqCnt_d;
      wdCnt_q  <= wdCnt_d;
      cause_q  <= cause_d;
      count_q  <= count_d;
      rstn_q   <= rstn_d;
      clkEn_q  <= clkEn_d;
      trig_q   <= trig_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign core_rstn_o           = rstn_q;
  assign core_clk_en_o         = clkEn_q;
  assign first_fetch_trigger_o = trig_q;
  assign busy_o                = busy_q;
  assign done_o                = done_q;
  assign stop_cause_o          = cause_q;
  assign cycle_count_o         = count_q;

endmodule
